// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO between the MMIO UART data register and the serializer.
// First-word fall-through head, occupancy counter, sticky overflow on dropped writes.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       flush,
  input  logic                       clear_overflow,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_out_valid,
  input  logic                       data_out_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             do_wr;
  logic             do_rd;

  // Full/empty come from the registered count only; a same-cycle dequeue never frees a slot early.
  assign full           = (count_q == CW'(DEPTH));
  assign empty          = (count_q == '0);
  assign data_out_valid = !empty;
  assign data_out       = mem[rd_ptr];
  assign count          = count_q;
  assign overflow       = overflow_q;

  assign do_wr = wr_en && !full && !flush;
  assign do_rd = data_out_valid && data_out_ready && !flush;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Set has priority so a drop in the clearing cycle is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (wr_en && full) begin
      overflow_q <= 1'b1;
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

endmodule
